// File: rtl/frogger_pkg.sv
// frogger_pkg -- shared definitions for the Frogger game controller.
//   Tile codes reported by the bitmap lookup at the frog tile, controller
//   state encoding, score ceiling, initial life count and the saturating
//   score increment used on lily-pad landings.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_DEAD      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    localparam logic [3:0] TILE_WALL  = 4'd0;
    localparam logic [3:0] TILE_ROAD  = 4'd1;
    localparam logic [3:0] TILE_WATER = 4'd2;
    localparam logic [3:0] TILE_SAFE  = 4'd3;
    localparam logic [3:0] TILE_LILY  = 4'd4;

    localparam logic [6:0] SCORE_MAX  = 7'd99;
    localparam logic [1:0] LIVES_INIT = 2'd3;

    function automatic logic [6:0] score_inc(input logic [6:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 7'd1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// debounce_filter -- single-bit debouncer.
//   The output follows the input only after the input has differed from the
//   output for c_LIMIT consecutive clocks; any shorter glitch is discarded.
// Ports:
//   i_Clk    system clock
//   i_Reset  asynchronous active-high reset (output and counter cleared)
//   i_Bit    synchronized button level
//   o_Bit    debounced button level
module debounce_filter #(
    parameter int unsigned c_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Bit,
    output logic o_Bit
);

    localparam int unsigned CW = (c_LIMIT > 1) ? $clog2(c_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(c_LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;

    always_comb begin
        cnt_d = '0;
        bit_d = bit_q;
        if (i_Bit != bit_q) begin
            if (cnt_q == CNT_LAST) begin
                bit_d = i_Bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q <= '0;
            bit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    assign o_Bit = bit_q;

endmodule

// File: rtl/frogger_ctrl.sv
// frogger_ctrl -- frog movement, life and score controller.
//   Buttons pass a 2-flop synchronizer; with FROGGER_DEBOUNCE_EN defined each
//   also passes a debounce_filter of c_DEBOUNCE_LIMIT stable cycles. A rising
//   edge of the cleaned level moves the frog one tile (Up>Down>Left>Right).
//   Per-cycle event priority while running: collision > drowning > lily pad
//   > movement.
// Ports:
//   i_Clk, i_Reset                   clock, async active-high reset
//   i_Up/Down/Left/Right_Mvt         movement buttons, active-high
//   i_Game_Active                    game enable
//   i_Collided, i_On_Log             car hit / log present at frog tile
//   i_Bitmap_Data                    tile code at frog tile
//   i_Col_Count_Div, i_Row_Count_Div current scan tile
//   i_Score                          score fed back from o_Score
//   o_Frogger_X, o_Frogger_Y         frog tile position
//   o_Score, o_Lives                 registered score / remaining lives
//   o_Draw_Frogger                   registered scan-tile == frog-tile flag
// Configuration macro: FROGGER_DEBOUNCE_EN
module frogger_ctrl
    import frogger_pkg::*;
#(
    parameter int c_GAME_WIDTH     = 20,
    parameter int c_GAME_HEIGHT    = 15,
    parameter int c_START_X        = 10,
    parameter int c_START_Y        = 14,
    parameter int c_DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Up_Mvt,
    input  logic       i_Down_Mvt,
    input  logic       i_Left_Mvt,
    input  logic       i_Right_Mvt,
    input  logic       i_Game_Active,
    input  logic       i_Collided,
    input  logic       i_On_Log,
    input  logic [3:0] i_Bitmap_Data,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [6:0] i_Score,
    output logic [5:0] o_Frogger_X,
    output logic [5:0] o_Frogger_Y,
    output logic [6:0] o_Score,
    output logic [1:0] o_Lives,
    output logic       o_Draw_Frogger
);

    localparam logic [5:0] START_X = 6'(c_START_X);
    localparam logic [5:0] START_Y = 6'(c_START_Y);
    localparam logic [5:0] MAX_X   = 6'(c_GAME_WIDTH - 1);
    localparam logic [5:0] MAX_Y   = 6'(c_GAME_HEIGHT - 1);

    // Button vectors: [3]=Up [2]=Down [1]=Left [0]=Right
    logic [3:0] btn_raw, btn_meta_q, btn_sync_q, btn_clean, btn_prev_q, btn_rise;

    assign btn_raw = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_clean;
        end
    end

`ifdef FROGGER_DEBOUNCE_EN
    for (genvar g = 0; g < 4; g++) begin : g_debounce
        debounce_filter #(
            .c_LIMIT(c_DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk  (i_Clk),
            .i_Reset(i_Reset),
            .i_Bit  (btn_sync_q[g]),
            .o_Bit  (btn_clean[g])
        );
    end
`else
    assign btn_clean = btn_sync_q;
    // The limit only matters with debouncing built in; keep it referenced.
    if (c_DEBOUNCE_LIMIT < 1) begin : g_limit_unused
    end
`endif

    assign btn_rise = btn_clean & ~btn_prev_q;

    state_e     state_q, state_d;
    logic [5:0] x_q, x_d, y_q, y_d;
    logic [6:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       draw_q, draw_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        lives_d = lives_q;
        draw_d  = ({1'b0, i_Col_Count_Div} == x_q) && ({1'b0, i_Row_Count_Div} == y_q);

        case (state_q)
            ST_IDLE: begin
                x_d = START_X;
                y_d = START_Y;
                if (i_Game_Active) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!i_Game_Active) begin
                    state_d = ST_IDLE;
                    x_d     = START_X;
                    y_d     = START_Y;
                end else if (i_Collided) begin
                    state_d = ST_DEAD;
                end else if (i_Bitmap_Data == TILE_WATER && !i_On_Log) begin
                    state_d = ST_DEAD;
                end else if (i_Bitmap_Data == TILE_LILY) begin
                    score_d = score_inc(i_Score);
                    x_d     = START_X;
                    y_d     = START_Y;
                end else if (btn_rise[3]) begin
                    if (y_q != '0) y_d = y_q - 6'd1;
                end else if (btn_rise[2]) begin
                    if (y_q != MAX_Y) y_d = y_q + 6'd1;
                end else if (btn_rise[1]) begin
                    if (x_q != '0) x_d = x_q - 6'd1;
                end else if (btn_rise[0]) begin
                    if (x_q != MAX_X) x_d = x_q + 6'd1;
                end
            end
            ST_DEAD: begin
                lives_d = lives_q - 2'd1;
                x_d     = START_X;
                y_d     = START_Y;
                state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_RUNNING;
            end
            ST_GAME_OVER: begin
                if (!i_Game_Active) begin
                    state_d = ST_IDLE;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            lives_q <= lives_d;
            draw_q  <= draw_d;
        end
    end

    assign o_Frogger_X    = x_q;
    assign o_Frogger_Y    = y_q;
    assign o_Score        = score_q;
    assign o_Lives        = lives_q;
    assign o_Draw_Frogger = draw_q;

endmodule

// File: tb/tb_frogger_ctrl.sv
// tb_frogger_ctrl -- directed self-checking bench for frogger_ctrl.
module tb_frogger_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic       i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt;
    logic       i_Game_Active, i_Collided, i_On_Log;
    logic [3:0] i_Bitmap_Data;
    logic [4:0] i_Col_Count_Div, i_Row_Count_Div;
    logic [6:0] i_Score;
    logic [5:0] o_Frogger_X, o_Frogger_Y;
    logic [6:0] o_Score;
    logic [1:0] o_Lives;
    logic       o_Draw_Frogger;

    int checks = 0;
    int errors = 0;

`ifdef FROGGER_DEBOUNCE_EN
    localparam int HOLD   = 8;
    localparam int SETTLE = 10;
`else
    localparam int HOLD   = 2;
    localparam int SETTLE = 4;
`endif

    frogger_ctrl #(
        .c_GAME_WIDTH    (20),
        .c_GAME_HEIGHT   (15),
        .c_START_X       (10),
        .c_START_Y       (14),
        .c_DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Up_Mvt       (i_Up_Mvt),
        .i_Down_Mvt     (i_Down_Mvt),
        .i_Left_Mvt     (i_Left_Mvt),
        .i_Right_Mvt    (i_Right_Mvt),
        .i_Game_Active  (i_Game_Active),
        .i_Collided     (i_Collided),
        .i_On_Log       (i_On_Log),
        .i_Bitmap_Data  (i_Bitmap_Data),
        .i_Col_Count_Div(i_Col_Count_Div),
        .i_Row_Count_Div(i_Row_Count_Div),
        .i_Score        (i_Score),
        .o_Frogger_X    (o_Frogger_X),
        .o_Frogger_Y    (o_Frogger_Y),
        .o_Score        (o_Score),
        .o_Lives        (o_Lives),
        .o_Draw_Frogger (o_Draw_Frogger)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_Clk);
            @(negedge i_Clk);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, ".x"}, 8'(o_Frogger_X), 8'(ex));
        check({tag, ".y"}, 8'(o_Frogger_Y), 8'(ey));
    endtask

    // m = {Up, Down, Left, Right}
    task automatic press(input logic [3:0] m, input int hold = HOLD);
        {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt} = m;
        tick(hold);
        {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt} = 4'b0000;
        tick(SETTLE);
    endtask

    // One-cycle tile event, then one more cycle for a DEAD state to resolve.
    task automatic tile_pulse(input logic [3:0] code, input logic log_bit);
        i_Bitmap_Data = code;
        i_On_Log      = log_bit;
        tick();
        i_Bitmap_Data = 4'd3;
        i_On_Log      = 1'b0;
        tick();
    endtask

    task automatic collide_pulse();
        i_Collided = 1'b1;
        tick();
        i_Collided = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        tick(2);
        i_Reset = 1'b0;
        tick();
    endtask

    initial begin
        i_Reset = 1'b1;
        {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt} = 4'b0000;
        i_Game_Active   = 1'b0;
        i_Collided      = 1'b0;
        i_On_Log        = 1'b0;
        i_Bitmap_Data   = 4'd3;
        i_Col_Count_Div = 5'd31;
        i_Row_Count_Div = 5'd31;
        i_Score         = 7'd0;
        tick(2);

        // Reset state
        check_pos("reset", 10, 14);
        check("reset.score", 8'(o_Score), 8'd0);
        check("reset.lives", 8'(o_Lives), 8'd3);
        check("reset.draw", 8'(o_Draw_Frogger), 8'd0);

        i_Reset = 1'b0;
        tick();
        // IDLE: presses ignored
        press(4'b1000);
        check_pos("idle_press", 10, 14);

        i_Game_Active = 1'b1;
        tick();
        press(4'b1000);
        check_pos("up1", 10, 13);
        check("up1.lives", 8'(o_Lives), 8'd3);
        check("up1.score", 8'(o_Score), 8'd0);

        // Left boundary
        repeat (10) press(4'b0010);
        check_pos("left10", 0, 13);
        repeat (2) press(4'b0010);
        check_pos("left12", 0, 13);

        // Up+Right together: Up wins
        press(4'b1001);
        check_pos("up_right", 0, 12);
        press(4'b0001);
        check_pos("right1", 1, 12);
        press(4'b0010);

        // Bottom boundary
        repeat (2) press(4'b0100);
        check_pos("down2", 0, 14);
        press(4'b0100);
        check_pos("down_edge", 0, 14);

        // Draw flag, registered
        i_Col_Count_Div = 5'd0;
        i_Row_Count_Div = 5'd14;
        tick();
        check("draw_hit", 8'(o_Draw_Frogger), 8'd1);
        i_Col_Count_Div = 5'd1;
        tick();
        check("draw_miss_col", 8'(o_Draw_Frogger), 8'd0);
        i_Col_Count_Div = 5'd0;
        i_Row_Count_Div = 5'd13;
        tick();
        check("draw_miss_row", 8'(o_Draw_Frogger), 8'd0);
        i_Row_Count_Div = 5'd31;

        // Water on a log: safe; wall tile: safe
        i_Bitmap_Data = 4'd2;
        i_On_Log      = 1'b1;
        tick(3);
        i_Bitmap_Data = 4'd0;
        tick(2);
        i_Bitmap_Data = 4'd3;
        i_On_Log      = 1'b0;
        tick();
        check_pos("log_safe", 0, 14);
        check("log_safe.lives", 8'(o_Lives), 8'd3);

        // Drowning
        tile_pulse(4'd2, 1'b0);
        check("drown.lives", 8'(o_Lives), 8'd2);
        check_pos("drown", 10, 14);
        tick(3);
        check("drown_hold.lives", 8'(o_Lives), 8'd2);

        // Lily pad, saturating score
        press(4'b1000);
        i_Score = 7'd98;
        tile_pulse(4'd4, 1'b0);
        check("lily98.score", 8'(o_Score), 8'd99);
        check_pos("lily98", 10, 14);
        press(4'b1000);
        i_Score = 7'd99;
        tile_pulse(4'd4, 1'b0);
        check("lily99.score", 8'(o_Score), 8'd99);
        check_pos("lily99", 10, 14);

        // Collision beats drowning: only one life lost
        i_Collided    = 1'b1;
        i_Bitmap_Data = 4'd2;
        tick();
        i_Collided    = 1'b0;
        i_Bitmap_Data = 4'd3;
        tick();
        check("coll_drown.lives", 8'(o_Lives), 8'd1);

        // Deactivate while running: back to spawn, score/lives kept
        press(4'b1000);
        check_pos("pre_idle", 10, 13);
        i_Game_Active = 1'b0;
        tick();
        check_pos("to_idle", 10, 14);
        check("to_idle.lives", 8'(o_Lives), 8'd1);
        check("to_idle.score", 8'(o_Score), 8'd99);
        i_Game_Active = 1'b1;
        tick();

        // Fresh game: score then three collisions to GAME_OVER
        do_reset();
        i_Score = 7'd5;
        tile_pulse(4'd4, 1'b0);
        check("lily5.score", 8'(o_Score), 8'd6);
        press(4'b0001);
        collide_pulse();
        check("coll1.lives", 8'(o_Lives), 8'd2);
        check_pos("coll1", 10, 14);
        collide_pulse();
        check("coll2.lives", 8'(o_Lives), 8'd1);
        collide_pulse();
        check("coll3.lives", 8'(o_Lives), 8'd0);
        press(4'b1000);
        check_pos("gameover_press", 10, 14);
        collide_pulse();
        i_Score = 7'd6;
        tile_pulse(4'd4, 1'b0);
        check("gameover.lives", 8'(o_Lives), 8'd0);
        check("gameover.score", 8'(o_Score), 8'd6);
        i_Game_Active = 1'b0;
        tick();
        check("restart.lives", 8'(o_Lives), 8'd3);
        check("restart.score", 8'(o_Score), 8'd0);
        i_Game_Active = 1'b1;
        tick();
        press(4'b1000);
        check_pos("restart_up", 10, 13);

        // Reset in the middle of a DEAD cycle
        collide_pulse();
        i_Collided = 1'b1;
        tick();
        i_Collided = 1'b0;
        i_Reset    = 1'b1;
        #1;
        check("mid_dead.lives", 8'(o_Lives), 8'd3);
        tick();
        i_Reset = 1'b0;
        tick(2);
        check("mid_dead_after.lives", 8'(o_Lives), 8'd3);

`ifdef FROGGER_DEBOUNCE_EN
        press(4'b1000, 3);
        check_pos("db_short", 10, 14);
        press(4'b1000, 6);
        check_pos("db_long", 10, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frogger_ctrl.md
FROGGER_CTRL -- requirements
Module: frogger_ctrl

Interface
REQ-001 SHALL have parameter c_GAME_WIDTH, default 20, playfield width in tiles.
REQ-002 SHALL have parameter c_GAME_HEIGHT, default 15, playfield height in tiles.
REQ-003 SHALL have parameter c_START_X, default 10, and c_START_Y, default 14, spawn tile.
REQ-004 SHALL have parameter c_DEBOUNCE_LIMIT, default 250000, stable-clock count per button.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 i_Clk  in  1  system clock (pixel clock).
REQ-007 i_Reset  in  1  asynchronous, active-high reset.
REQ-008 i_Up_Mvt / i_Down_Mvt / i_Left_Mvt / i_Right_Mvt  in  1 each  movement buttons, active-high.
REQ-009 i_Game_Active  in  1  game enable.
REQ-010 i_Collided  in  1  car hit on frog tile.
REQ-011 i_On_Log  in  1  frog tile carries a log.
REQ-012 i_Bitmap_Data  in  4  tile code at the frog tile: 0 wall, 1 road, 2 water, 3 safe, 4 lily pad.
REQ-013 i_Col_Count_Div / i_Row_Count_Div  in  5 each  current scan tile.
REQ-014 i_Score  in  7  current score, fed back from o_Score.
REQ-015 o_Frogger_X / o_Frogger_Y  out  6 each  frog tile position.
REQ-016 o_Score  out  7  registered score.
REQ-017 o_Lives  out  2  remaining lives.
REQ-018 o_Draw_Frogger  out  1  scan tile equals frog tile.

Function
REQ-019 States SHALL be IDLE, RUNNING, DEAD, GAME_OVER.
REQ-020 IDLE: frog held at (c_START_X, c_START_Y); IDLE->RUNNING when i_Game_Active=1.
REQ-021 RUNNING, i_Game_Active=0: next cycle ->IDLE, frog to spawn, score and lives kept.
REQ-022 Move: one tile per debounced rising edge; one move per cycle; simultaneous edges priority Up>Down>Left>Right, others dropped.
REQ-023 Up decrements Y, Down increments Y, Left decrements X, Right increments X.
REQ-024 Boundaries: no move below 0 or beyond c_GAME_WIDTH-1 / c_GAME_HEIGHT-1; press ignored, no wrap.
REQ-025 Event priority per cycle: collision > drowning > lily pad > movement.
REQ-026 Collision (RUNNING, i_Collided=1) SHALL enter DEAD.
REQ-027 Drowning (RUNNING, i_Bitmap_Data=2, i_On_Log=0) SHALL enter DEAD.
REQ-028 DEAD: one cycle; lives decrement; frog to spawn; lives reaching 0 ->GAME_OVER, else ->RUNNING.
REQ-029 Lily pad (RUNNING, i_Bitmap_Data=4): o_Score<=i_Score+1, saturating at 99; frog to spawn; stay RUNNING.
REQ-030 Wall tile (0): treated as safe, no event.
REQ-031 GAME_OVER: frog frozen, inputs ignored; ->IDLE on i_Game_Active=0 with lives<=3, score<=0.
REQ-032 o_Draw_Frogger SHALL be registered, one cycle after scan inputs, high only when both equal frog position.
REQ-033 Position and score updates SHALL be visible on outputs one clock after the triggering edge.

Reset
REQ-034 Reset SHALL force IDLE, frog at spawn, o_Score=0, o_Lives=3, o_Draw_Frogger=0, debouncers cleared.
REQ-035 Reset mid-move or mid-DEAD SHALL abort the event with no score or lives change.

Configuration
REQ-036 FROGGER_DEBOUNCE_EN defined: each button passes a 2-flop synchronizer and a debouncer of c_DEBOUNCE_LIMIT stable cycles.
REQ-037 FROGGER_DEBOUNCE_EN undefined: 2-flop synchronizer only; edges act 2 cycles after input change.

Structure
REQ-038 Package frogger_pkg SHALL hold tile codes 0-4, state encodings, score max 99, initial lives 3.
REQ-039 Sub-module debounce_filter (one per button), instantiated only under FROGGER_DEBOUNCE_EN.

Verification (bench with FROGGER_DEBOUNCE_EN undefined unless noted)
REQ-040 Reset, i_Game_Active=1, pulse Up -> frog (10,13), o_Lives=3, o_Score=0.
REQ-041 Hold Left 12 separate presses from X=10 -> X=0, X stays 0; Up+Right same cycle -> only Y decrements.
REQ-042 i_Bitmap_Data=2, i_On_Log=0 -> DEAD, o_Lives=2, frog (10,14); with i_On_Log=1 -> no change.
REQ-043 i_Bitmap_Data=4, i_Score=98 -> o_Score=99; i_Score=99 -> o_Score stays 99; frog to spawn.
REQ-044 Three i_Collided pulses -> o_Lives 2,1,0, GAME_OVER, presses ignored; i_Game_Active=0 -> IDLE, lives 3, score 0.
REQ-045 With FROGGER_DEBOUNCE_EN, c_DEBOUNCE_LIMIT=4: 3-cycle Up pulse -> no move; 6-cycle pulse -> one move.
